// File: rtl/cpu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// cpu_seq_ctrl
//
// Multi-cycle sequencer for a simple non-pipelined CPU. Each instruction walks
// FETCH -> DECODE -> EXEC -> [MEM] -> WB and returns to FETCH. Memory requests
// are held stable until the memory answers with mem_ready or a wait timeout
// fires. Timeouts and misaligned data accesses park the sequencer in FAULT,
// which only rst can leave.
//
// Optional feature (macro CPU_SEQ_PERF_CNT_EN):
//   defined   -> cycle_cnt counts every non-FAULT cycle, instret_cnt counts
//                retired instructions, both 32-bit wrapping.
//   undefined -> both counter outputs are tied to 0 and no counter
//                registers exist.
//
// Parameters:
//   AW        address width (>= 3)
//   DW        data / instruction width
//   RESET_PC  PC after reset (word aligned)
//   TIMEOUT   maximum wait cycles per memory request (1..65535)
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   ena                       run enable, sampled only in FETCH
//   mem_req/mem_we            memory request and write qualifier
//   mem_addr/mem_wdata        word address and store data
//   mem_ready/mem_rdata       completion strobe and read data
//   dec_mem_rd/wr, dec_gp_we  decoder controls for the current instruction
//   alu_addr/store_data       data address and store data from the datapath
//   next_pc                   PC of the following instruction
//   pc/instr/load_data        architectural PC, fetched word, load result
//   gpr_we/retired            one-cycle writeback and retire strobes in WB
//   state                     FSM encoding (FETCH=0 .. FAULT=5)
//   fault/fault_code          sticky fault flag and cause
//                             (01 fetch timeout, 10 misaligned, 11 data timeout)
//   cycle_cnt/instret_cnt     performance counters
// -----------------------------------------------------------------------------
module cpu_seq_ctrl #(
    parameter int          AW       = 32,
    parameter int          DW       = 32,
    parameter logic [AW-1:0] RESET_PC = '0,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    input  logic [DW-1:0] mem_rdata,
    input  logic          dec_mem_rd,
    input  logic          dec_mem_wr,
    input  logic          dec_gp_we,
    input  logic [AW-1:0] alu_addr,
    input  logic [DW-1:0] store_data,
    input  logic [AW-1:0] next_pc,
    output logic [AW-1:0] pc,
    output logic [DW-1:0] instr,
    output logic [DW-1:0] load_data,
    output logic          gpr_we,
    output logic          retired,
    output logic [2:0]    state,
    output logic          fault,
    output logic [1:0]    fault_code,
    output logic [31:0]   cycle_cnt,
    output logic [31:0]   instret_cnt
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    localparam logic [1:0] FC_FETCH_TO  = 2'b01;
    localparam logic [1:0] FC_MISALIGN  = 2'b10;
    localparam logic [1:0] FC_DATA_TO   = 2'b11;

    // Clears the byte-offset bits of any address leaving the block.
    localparam logic [AW-1:0] ALIGN_MASK  = {{(AW-2){1'b1}}, 2'b00};
    localparam logic [15:0]   TIMEOUT_CNT = 16'(TIMEOUT);

    // -------------------------------------------------------------------------
    // State and registered outputs
    // -------------------------------------------------------------------------
    state_t        r_state;
    logic [AW-1:0] r_pc;
    logic [DW-1:0] r_instr;
    logic [DW-1:0] r_load_data;
    logic          r_mem_req;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic          r_gpr_we;
    logic          r_retired;
    logic          r_fault;
    logic [1:0]    r_fault_code;
    logic [15:0]   r_wait_cnt;

    // -------------------------------------------------------------------------
    // Combinational helpers
    // -------------------------------------------------------------------------
    logic [15:0]   w_wait_next;
    logic          w_timeout;
    logic          w_is_mem;
    logic          w_misaligned;
    logic [AW-1:0] w_fetch_addr;
    logic [AW-1:0] w_data_addr;
    logic [AW-1:0] w_next_pc;

    assign w_wait_next  = r_wait_cnt + 16'd1;
    // A timeout needs the request still unanswered this cycle, so a mem_ready
    // arriving on the very cycle the count would hit TIMEOUT wins.
    assign w_timeout    = r_mem_req && !mem_ready && (w_wait_next == TIMEOUT_CNT);
    assign w_is_mem     = dec_mem_rd || dec_mem_wr;
    assign w_misaligned = (alu_addr[1:0] != 2'b00);
    assign w_fetch_addr = r_pc & ALIGN_MASK;
    assign w_data_addr  = alu_addr & ALIGN_MASK;
    assign w_next_pc    = next_pc & ALIGN_MASK;

    // -------------------------------------------------------------------------
    // Sequencer FSM
    // -------------------------------------------------------------------------
    // NOTE: every register here uses non-blocking assignment so that all
    // branches read the pre-edge values of the state, regardless of order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_FETCH;
            r_pc         <= RESET_PC;
            r_instr      <= '0;
            r_load_data  <= '0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_gpr_we     <= 1'b0;
            r_retired    <= 1'b0;
            r_fault      <= 1'b0;
            r_fault_code <= 2'b00;
            r_wait_cnt   <= '0;
        end else begin
            // NOTE: the strobes default low every cycle; only the edge that
            // enters WB raises them, which makes them exactly one cycle wide.
            r_gpr_we  <= 1'b0;
            r_retired <= 1'b0;

            if (r_mem_req && !mem_ready) begin
                r_wait_cnt <= w_wait_next;
            end

            case (r_state)
                S_FETCH: begin
                    if (!r_mem_req) begin
                        // Idle: mem_ready is ignored here, ena starts a fetch.
                        if (ena) begin
                            r_mem_req  <= 1'b1;
                            r_mem_we   <= 1'b0;
                            r_mem_addr <= w_fetch_addr;
                            r_wait_cnt <= '0;
                        end
                    end else if (mem_ready) begin
                        r_instr   <= mem_rdata;
                        r_mem_req <= 1'b0;
                        r_state   <= S_DECODE;
                    end else if (w_timeout) begin
                        r_mem_req    <= 1'b0;
                        r_fault      <= 1'b1;
                        r_fault_code <= FC_FETCH_TO;
                        r_state      <= S_FAULT;
                    end
                end

                S_DECODE: begin
                    r_state <= S_EXEC;
                end

                S_EXEC: begin
                    if (w_is_mem) begin
                        if (w_misaligned) begin
                            r_fault      <= 1'b1;
                            r_fault_code <= FC_MISALIGN;
                            r_state      <= S_FAULT;
                        end else begin
                            // Request is raised on entry to MEM so it is
                            // already stable during the first MEM cycle.
                            // A write wins when both rd and wr are set.
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= dec_mem_wr;
                            r_mem_addr  <= w_data_addr;
                            r_mem_wdata <= store_data;
                            r_wait_cnt  <= '0;
                            r_state     <= S_MEM;
                        end
                    end else begin
                        r_gpr_we  <= dec_gp_we;
                        r_retired <= 1'b1;
                        r_state   <= S_WB;
                    end
                end

                S_MEM: begin
                    if (mem_ready) begin
                        if (!r_mem_we) begin
                            r_load_data <= mem_rdata;
                        end
                        r_mem_req <= 1'b0;
                        r_gpr_we  <= dec_gp_we;
                        r_retired <= 1'b1;
                        r_state   <= S_WB;
                    end else if (w_timeout) begin
                        r_mem_req    <= 1'b0;
                        r_fault      <= 1'b1;
                        r_fault_code <= FC_DATA_TO;
                        r_state      <= S_FAULT;
                    end
                end

                S_WB: begin
                    r_pc    <= w_next_pc;
                    r_state <= S_FETCH;
                end

                S_FAULT: begin
                    // Terminal until rst; mem_req is already low.
                    r_mem_req <= 1'b0;
                end

                default: begin
                    r_mem_req <= 1'b0;
                    r_fault   <= 1'b1;
                    r_state   <= S_FAULT;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Optional performance counters
    // -------------------------------------------------------------------------
`ifdef CPU_SEQ_PERF_CNT_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_instret_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle_cnt   <= '0;
            r_instret_cnt <= '0;
        end else begin
            if (r_state != S_FAULT) begin
                r_cycle_cnt <= r_cycle_cnt + 32'd1;
            end
            if (r_retired) begin
                r_instret_cnt <= r_instret_cnt + 32'd1;
            end
        end
    end

    assign cycle_cnt   = r_cycle_cnt;
    assign instret_cnt = r_instret_cnt;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

    // -------------------------------------------------------------------------
    // Output mapping
    // -------------------------------------------------------------------------
    assign mem_req    = r_mem_req;
    assign mem_we     = r_mem_we;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign pc         = r_pc;
    assign instr      = r_instr;
    assign load_data  = r_load_data;
    assign gpr_we     = r_gpr_we;
    assign retired    = r_retired;
    assign state      = r_state;
    assign fault      = r_fault;
    assign fault_code = r_fault_code;

endmodule
